draw_sequencer: RTL and testbench

DRAW_SEQUENCER -- requirements
Module: draw_sequencer

---
 rtl/draw_seq_pkg.sv | 9 +
 rtl/draw_sequencer_if.sv | 14 +
 rtl/draw_sequencer_slot_finder.sv | 20 ++
 rtl/draw_sequencer.sv | 106 ++++++++++
 tb/tb_draw_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/draw_seq_pkg.sv
// draw_seq_pkg: shared FSM states, idle/clear command and default sizes for draw_sequencer.
package draw_seq_pkg;
    typedef enum logic [1:0] {IDLE, CLEAR, DRAW, FLUSH} state_e;
    localparam logic [4:0] CMD_IDLE = 5'b01111;
    localparam int DEF_NUM_SLOTS = 15;
    localparam int DEF_SLOT_CYCLES = 16;
    localparam int DEF_CLEAR_CYCLES = 162 * 122;
    localparam int IDX_W = 4;
endpackage

// File: rtl/draw_sequencer_if.sv
// draw_sequencer_if: frame request and drawing-datapath command bundle of draw_sequencer.
interface draw_sequencer_if import draw_seq_pkg::*; #(
    parameter int NUM_SLOTS = DEF_NUM_SLOTS
);
    logic                 frame_tick;
    logic [NUM_SLOTS-1:0] active;
    logic [4:0]           command;
    logic                 plot;
    logic                 busy;
    logic                 done;
    logic                 overrun;
    modport master (output frame_tick, active, input command, plot, busy, done, overrun);
    modport slave (input frame_tick, active, output command, plot, busy, done, overrun);
endinterface

// File: rtl/draw_sequencer_slot_finder.sv
// slot_finder: lowest set bit of vec_i at or above from_i, none_o when no such bit exists.
module slot_finder import draw_seq_pkg::*; #(
    parameter int N = DEF_NUM_SLOTS
) (
    input  logic [N-1:0]     vec_i,
    input  logic [IDX_W-1:0] from_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             none_o
);
    always_comb begin
        idx_o = '0;
        none_o = 1'b1;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec_i[i] && i >= int'(from_i)) begin
                idx_o = IDX_W'(i);
                none_o = 1'b0;
            end
        end
    end
endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: per-frame clear scan then 4x4 slot draws; the clear phase exists only
// when DRAW_SEQ_CLEAR_EN is defined.
module draw_sequencer import draw_seq_pkg::*; #(
    parameter int NUM_SLOTS    = DEF_NUM_SLOTS,
    parameter int SLOT_CYCLES  = DEF_SLOT_CYCLES,
    parameter int CLEAR_CYCLES = DEF_CLEAR_CYCLES
) (
    input logic              CLK,
    input logic              reset,
    draw_sequencer_if.slave  bus
);
    localparam int CNT_MAX = CLEAR_CYCLES > SLOT_CYCLES ? CLEAR_CYCLES : SLOT_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);
`ifdef DRAW_SEQ_CLEAR_EN
    localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_CYCLES - 1);
`endif

    state_e               state_q;
    logic [NUM_SLOTS-1:0] active_q;
    logic [IDX_W-1:0]     slot_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [4:0]           command_q;
    logic                 plot_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 overrun_q;
    logic [IDX_W-1:0]     find_idx;
    logic                 find_none;
    state_e               draw_state;
    logic [4:0]           draw_cmd;

    // In IDLE the live mask is searched so a clear-less frame can start drawing immediately
    slot_finder #(.N(NUM_SLOTS)) u_finder (
        .vec_i  (state_q == IDLE ? bus.active : active_q),
        .from_i (state_q == DRAW ? slot_q + 1'b1 : '0),
        .idx_o  (find_idx),
        .none_o (find_none)
    );

    assign draw_state = find_none ? FLUSH : DRAW;
    assign draw_cmd = find_none ? CMD_IDLE : {1'b1, find_idx};

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q   <= IDLE;
            active_q  <= '0;
            slot_q    <= '0;
            cnt_q     <= '0;
            command_q <= CMD_IDLE;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            plot_q    <= state_q == CLEAR || state_q == DRAW;
            overrun_q <= bus.frame_tick && (busy_q || done_q);
            done_q    <= 1'b0;
            case (state_q)
                IDLE: if (bus.frame_tick && !done_q) begin
                    active_q <= bus.active;
                    busy_q   <= 1'b1;
                    cnt_q    <= '0;
`ifdef DRAW_SEQ_CLEAR_EN
                    state_q   <= CLEAR;
                    command_q <= CMD_IDLE;
`else
                    state_q   <= draw_state;
                    slot_q    <= find_idx;
                    command_q <= draw_cmd;
`endif
                end
`ifdef DRAW_SEQ_CLEAR_EN
                CLEAR: if (cnt_q == CLEAR_LAST) begin
                    cnt_q     <= '0;
                    state_q   <= draw_state;
                    slot_q    <= find_idx;
                    command_q <= draw_cmd;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
`endif
                DRAW: if (cnt_q == SLOT_LAST) begin
                    cnt_q     <= '0;
                    state_q   <= draw_state;
                    slot_q    <= find_idx;
                    command_q <= draw_cmd;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
                FLUSH: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.command = command_q;
    assign bus.plot    = plot_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_draw_sequencer.sv
// tb_draw_sequencer: per-cycle scoreboard of expected outputs plus a frame-length/plot table.
module tb_draw_sequencer;
    import draw_seq_pkg::*;
    localparam int NS = 15;
    localparam int SC = 16;
    localparam int CLR = 20;
`ifdef DRAW_SEQ_CLEAR_EN
    localparam int CC = CLR;
`else
    localparam int CC = 0;
`endif

    typedef struct packed {
        logic [4:0] cmd;
        logic       plot;
        logic       busy;
        logic       done;
        logic       ovr;
    } rec_t;

    typedef struct {
        logic [NS-1:0] act;
        int            len;
        int            plots;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    draw_sequencer_if #(.NUM_SLOTS(NS)) bus ();
    draw_sequencer #(.NUM_SLOTS(NS), .SLOT_CYCLES(SC), .CLEAR_CYCLES(CLR)) dut (
        .CLK   (clk),
        .reset (rst),
        .bus   (bus)
    );

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   done_at = -1;
    int   plot_cnt = 0;
    logic prev_plot = 1'b0;

    function automatic void push_state(input logic [4:0] cmd, input logic plotting);
        exp_q.push_back({cmd, prev_plot, 1'b1, 1'b0, 1'b0});
        prev_plot = plotting;
    endfunction

    function automatic void push_idle(input int n);
        for (int k = 0; k < n; k++) exp_q.push_back({CMD_IDLE, 4'b0000});
    endfunction

    // Expected output stream of one frame: clear scan, ascending slots, flush, done, one idle
    function automatic void push_frame(input logic [NS-1:0] act);
        prev_plot = 1'b0;
        for (int k = 0; k < CC; k++) push_state(CMD_IDLE, 1'b1);
        for (int s = 0; s < NS; s++)
            if (act[s]) for (int k = 0; k < SC; k++) push_state({1'b1, 4'(s)}, 1'b1);
        push_state(CMD_IDLE, 1'b0);
        exp_q.push_back({CMD_IDLE, prev_plot, 1'b0, 1'b1, 1'b0});
        push_idle(1);
    endfunction

    task automatic tick();
        rec_t a;
        rec_t e;
        @(posedge clk);
        #1;
        cyc++;
        a = {bus.command, bus.plot, bus.busy, bus.done, bus.overrun};
        if (bus.plot) plot_cnt++;
        if (bus.done && done_at < 0) done_at = cyc;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs cyc=%0d got cmd=%b plot=%b busy=%b done=%b ovr=%b want cmd=%b plot=%b busy=%b done=%b ovr=%b",
                         cyc, a.cmd, a.plot, a.busy, a.done, a.ovr, e.cmd, e.plot, e.busy, e.done, e.ovr);
            end
        end
    endtask

    task automatic drain();
        while (exp_q.size() > 0) tick();
    endtask

    task automatic start_frame(input logic [NS-1:0] act);
        bus.active = act;
        bus.frame_tick = 1'b1;
        push_frame(act);
        cyc = 0;
        done_at = -1;
        plot_cnt = 0;
        tick();
        bus.frame_tick = 1'b0;
        bus.active = ~act;
    endtask

    task automatic check_int(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", name, got, want);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        rec_t r;
        vecs = '{'{15'h0001, CC + 17, CC + 16},
                 '{15'h4005, CC + 49, CC + 48},
                 '{15'h0000, CC + 1,  CC},
                 '{15'h0003, CC + 33, CC + 32},
                 '{15'h7fff, CC + 241, CC + 240}};
        bus.frame_tick = 1'b0;
        bus.active = '0;
        push_idle(2);
        tick();
        tick();
        rst = 1'b0;
        push_idle(2);
        drain();

        for (int v = 0; v < 5; v++) begin
            start_frame(vecs[v].act);
            drain();
            check_int($sformatf("frame_len act=%h", vecs[v].act), done_at - 1, vecs[v].len);
            check_int($sformatf("plot_count act=%h", vecs[v].act), plot_cnt, vecs[v].plots);
        end

        // frame_tick during DRAW and again coincident with done: both are overruns
        start_frame(15'h0001);
        while (cyc < CC + 5) tick();
        bus.frame_tick = 1'b1;
        bus.active = 15'h7fff;
        r = exp_q.pop_front();
        r.ovr = 1'b1;
        exp_q.push_front(r);
        tick();
        bus.frame_tick = 1'b0;
        while (done_at < 0 && exp_q.size() > 0) tick();
        check_int("overrun_frame_len", done_at - 1, CC + 17);
        if (exp_q.size() > 0) begin
            r = exp_q.pop_front();
            r.ovr = 1'b1;
            exp_q.push_front(r);
        end
        bus.frame_tick = 1'b1;
        tick();
        bus.frame_tick = 1'b0;
        push_idle(3);
        drain();

        // reset during slot 2 aborts the frame without done; next frame restarts cleanly
        start_frame(15'h4005);
        while (cyc < CC + 21) tick();
        rst = 1'b1;
        exp_q.delete();
        push_idle(1);
        tick();
        rst = 1'b0;
        done_at = -1;
        push_idle(3);
        drain();
        check_int("reset_no_done", done_at, -1);
        start_frame(15'h4005);
        drain();
        check_int("restart_frame_len", done_at - 1, CC + 49);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
